ramp_checker: RTL and testbench

RAMP_CHECKER -- requirements
Module: ramp_checker

---
 rtl/ramp_checker.sv | 140 ++++++++++++++
 tb/tb_ramp_checker.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ramp_checker.sv
// Checks a sample stream for a full 0 -> max -> 0 ramp, one sample per tick.
// Reports peak, completion pulse, sticky error flag and a saturating error count.
module ramp_checker #(
    parameter int Width       = 8,
    parameter int ErrCntWidth = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   arm_i,
    input  logic                   tick_i,
    input  logic [Width-1:0]       data_i,
    output logic                   busy_o,
    output logic                   up_o,
    output logic [Width-1:0]       peak_o,
    output logic                   done_o,
    output logic                   err_o,
    output logic [ErrCntWidth-1:0] err_cnt_o
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_ZERO = 2'd1,
        RISE      = 2'd2,
        FALL      = 2'd3
    } state_t;

    localparam logic [Width-1:0]       SampleOne = {{(Width-1){1'b0}}, 1'b1};
    localparam logic [Width-1:0]       SampleMax = '1;
    localparam logic [ErrCntWidth-1:0] CntOne    = {{(ErrCntWidth-1){1'b0}}, 1'b1};
    localparam logic [ErrCntWidth-1:0] CntMax    = '1;

    state_t                 state_q, state_d;
    logic [Width-1:0]       prev_q, prev_d;
    logic [Width-1:0]       peak_q, peak_d;
    logic                   err_q, err_d;
    logic [ErrCntWidth-1:0] err_cnt_q, err_cnt_d;
    logic                   done_q, done_d;
    logic                   busy_q, busy_d;
    logic                   up_q, up_d;

    logic [Width-1:0]       prev_inc;
    logic [Width-1:0]       prev_dec;
    logic                   step_err;

    assign prev_inc = prev_q + SampleOne;
    assign prev_dec = prev_q - SampleOne;

    always_comb begin
        state_d   = state_q;
        prev_d    = prev_q;
        peak_d    = peak_q;
        err_d     = err_q;
        err_cnt_d = err_cnt_q;
        done_d    = 1'b0;
        step_err  = 1'b0;

        // Arm wins over a coincident tick; that sample is dropped.
        if (arm_i) begin
            state_d   = WAIT_ZERO;
            prev_d    = '0;
            peak_d    = '0;
            err_d     = 1'b0;
            err_cnt_d = '0;
        end else if (tick_i) begin
            case (state_q)
                WAIT_ZERO: begin
                    if (data_i == '0) begin
                        state_d = RISE;
                        prev_d  = '0;
                    end
                end
                RISE: begin
                    if (data_i == prev_inc) begin
                        prev_d = data_i;
                        peak_d = data_i;
                        if (data_i == SampleMax) begin
                            state_d = FALL;
                        end
                    end else if (data_i != prev_q) begin
                        step_err = 1'b1;
                    end
                end
                FALL: begin
                    if (data_i == prev_dec) begin
                        prev_d = data_i;
                        if (data_i == '0) begin
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end
                    end else if (data_i != prev_q) begin
                        step_err = 1'b1;
                    end
                end
                default: ;
            endcase

            // Resync on the bad sample so one glitch costs a single error.
            if (step_err) begin
                err_d  = 1'b1;
                prev_d = data_i;
                if (err_cnt_q != CntMax) begin
                    err_cnt_d = err_cnt_q + CntOne;
                end
            end
        end

        busy_d = (state_d != IDLE);
        up_d   = (state_d == RISE);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= IDLE;
            prev_q    <= '0;
            peak_q    <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            up_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            prev_q    <= prev_d;
            peak_q    <= peak_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            up_q      <= up_d;
        end
    end

    assign busy_o    = busy_q;
    assign up_o      = up_q;
    assign peak_o    = peak_q;
    assign done_o    = done_q;
    assign err_o     = err_q;
    assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_ramp_checker.sv
// Self-checking bench for ramp_checker: vector table, directed ramps,
// randomized traffic against a behavioural model, and a 2-bit counter instance.
module tb_ramp_checker;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic       arm_i = 1'b0;
    logic       tick_i = 1'b0;
    logic [7:0] data_i = 8'd0;
    logic       busy_o, up_o, done_o, err_o;
    logic [7:0] peak_o, err_cnt_o;

    logic       arm2_i = 1'b0;
    logic       tick2_i = 1'b0;
    logic [7:0] data2_i = 8'd0;
    logic       busy2_o, up2_o, done2_o, err2_o;
    logic [7:0] peak2_o;
    logic [1:0] err_cnt2_o;

    int total = 0;
    int bad = 0;
    int done_seen = 0;

    localparam int PH_IDLE = 0;
    localparam int PH_WZ   = 1;
    localparam int PH_RISE = 2;
    localparam int PH_FALL = 3;

    int m_phase = PH_IDLE;
    int m_prev = 0;
    int m_peak = 0;
    int m_err = 0;
    int m_cnt = 0;
    int m_done = 0;

    always #5 clk_i = ~clk_i;

    ramp_checker #(.Width(8), .ErrCntWidth(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .arm_i(arm_i), .tick_i(tick_i), .data_i(data_i),
        .busy_o(busy_o), .up_o(up_o), .peak_o(peak_o), .done_o(done_o),
        .err_o(err_o), .err_cnt_o(err_cnt_o)
    );

    ramp_checker #(.Width(8), .ErrCntWidth(2)) dut_sat (
        .clk_i(clk_i), .rst_i(rst_i), .arm_i(arm2_i), .tick_i(tick2_i), .data_i(data2_i),
        .busy_o(busy2_o), .up_o(up2_o), .peak_o(peak2_o), .done_o(done2_o),
        .err_o(err2_o), .err_cnt_o(err_cnt2_o)
    );

    typedef struct {
        logic       arm;
        logic       tick;
        logic [7:0] data;
        logic       busy;
        logic       up;
        logic [7:0] peak;
        logic       done;
        logic       err;
        logic [7:0] cnt;
    } vec_t;

    task automatic model_reset();
        m_phase = PH_IDLE; m_prev = 0; m_peak = 0; m_err = 0; m_cnt = 0; m_done = 0;
    endtask

    task automatic model_error(input int d);
        m_err = 1;
        if (m_cnt < 255) m_cnt = m_cnt + 1;
        m_prev = d;
    endtask

    task automatic model_step(input logic a, input logic t, input int d);
        m_done = 0;
        if (!rst_i) begin
            model_reset();
        end else if (a) begin
            m_phase = PH_WZ; m_prev = 0; m_peak = 0; m_err = 0; m_cnt = 0;
        end else if (t) begin
            if (m_phase == PH_WZ) begin
                if (d == 0) begin m_phase = PH_RISE; m_prev = 0; end
            end else if (m_phase == PH_RISE) begin
                if (d == (m_prev + 1) % 256) begin
                    m_prev = d; m_peak = d;
                    if (d == 255) m_phase = PH_FALL;
                end else if (d != m_prev) begin
                    model_error(d);
                end
            end else if (m_phase == PH_FALL) begin
                if (d == (m_prev + 255) % 256) begin
                    m_prev = d;
                    if (d == 0) begin m_done = 1; m_phase = PH_IDLE; end
                end else if (d != m_prev) begin
                    model_error(d);
                end
            end
        end
    endtask

    task automatic check(input string name);
        logic [19:0] got, exp;
        got = {busy_o, up_o, peak_o, done_o, err_o, err_cnt_o};
        exp = {m_phase != PH_IDLE, m_phase == PH_RISE, 8'(m_peak), m_done == 1,
               m_err == 1, 8'(m_cnt)};
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got{busy,up,peak,done,err,cnt}=%h exp=%h", name, got, exp);
        end
        if (done_o === 1'b1) done_seen++;
    endtask

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic step(input logic a, input logic t, input logic [7:0] d, input string name);
        @(negedge clk_i);
        arm_i = a; tick_i = t; data_i = d;
        @(posedge clk_i);
        model_step(a, t, int'(d));
        #1;
        arm_i = 1'b0; tick_i = 1'b0;
        check(name);
        $display("txn %s arm=%0d tick=%0d d=%0d busy=%0d up=%0d peak=%0d done=%0d err=%0d cnt=%0d",
                 name, a, t, d, busy_o, up_o, peak_o, done_o, err_o, err_cnt_o);
    endtask

    task automatic ramp_up(input int from, input int to, input string name);
        for (int v = from; v <= to; v++) step(1'b0, 1'b1, 8'(v), name);
    endtask

    task automatic ramp_down(input int from, input int to, input string name);
        for (int v = from; v >= to; v--) step(1'b0, 1'b1, 8'(v), name);
    endtask

    task automatic sat_step(input logic a, input logic t, input logic [7:0] d,
                            input int exp_cnt, input int exp_err);
        @(negedge clk_i);
        arm2_i = a; tick2_i = t; data2_i = d;
        @(posedge clk_i);
        #1;
        arm2_i = 1'b0; tick2_i = 1'b0;
        chk("sat_cnt", int'(err_cnt2_o), exp_cnt);
        chk("sat_err", int'(err2_o), exp_err);
        $display("txn sat arm=%0d tick=%0d d=%0d err=%0d cnt=%0d", a, t, d, err2_o, err_cnt2_o);
    endtask

    initial begin
        vec_t vecs[12];
        vecs[0]  = '{1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0};
        vecs[1]  = '{1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0};
        vecs[2]  = '{1'b0, 1'b1, 8'd9, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0};
        vecs[3]  = '{1'b0, 1'b1, 8'd0, 1'b1, 1'b1, 8'd0, 1'b0, 1'b0, 8'd0};
        vecs[4]  = '{1'b0, 1'b1, 8'd1, 1'b1, 1'b1, 8'd1, 1'b0, 1'b0, 8'd0};
        vecs[5]  = '{1'b0, 1'b1, 8'd1, 1'b1, 1'b1, 8'd1, 1'b0, 1'b0, 8'd0};
        vecs[6]  = '{1'b0, 1'b1, 8'd4, 1'b1, 1'b1, 8'd1, 1'b0, 1'b1, 8'd1};
        vecs[7]  = '{1'b0, 1'b1, 8'd5, 1'b1, 1'b1, 8'd5, 1'b0, 1'b1, 8'd1};
        vecs[8]  = '{1'b0, 1'b0, 8'd6, 1'b1, 1'b1, 8'd5, 1'b0, 1'b1, 8'd1};
        vecs[9]  = '{1'b0, 1'b1, 8'd3, 1'b1, 1'b1, 8'd5, 1'b0, 1'b1, 8'd2};
        vecs[10] = '{1'b1, 1'b1, 8'd4, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0};
        vecs[11] = '{1'b0, 1'b1, 8'd0, 1'b1, 1'b1, 8'd0, 1'b0, 1'b0, 8'd0};

        // Reset state
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        check("reset");
        chk("reset_sat_cnt", int'(err_cnt2_o), 0);
        rst_i = 1'b1;

        // Vector table
        for (int i = 0; i < 12; i++) begin
            logic [19:0] got, exp;
            step(vecs[i].arm, vecs[i].tick, vecs[i].data, "vec");
            got = {busy_o, up_o, peak_o, done_o, err_o, err_cnt_o};
            exp = {vecs[i].busy, vecs[i].up, vecs[i].peak, vecs[i].done, vecs[i].err, vecs[i].cnt};
            chk($sformatf("vec%0d", i), int'(got), int'(exp));
        end

        // Clean ramp
        step(1'b1, 1'b0, 8'd0, "clean_arm");
        done_seen = 0;
        ramp_up(0, 255, "clean");
        ramp_down(254, 0, "clean");
        step(1'b0, 1'b0, 8'd0, "clean_after");
        chk("clean_done_count", done_seen, 1);
        chk("clean_peak", int'(peak_o), 255);
        chk("clean_err", int'(err_o), 0);
        chk("clean_busy", int'(busy_o), 0);

        // Step error: 0,1,2,5,6..255..0
        step(1'b1, 1'b0, 8'd0, "err_arm");
        done_seen = 0;
        ramp_up(0, 2, "stepErr");
        ramp_up(5, 255, "stepErr");
        ramp_down(254, 0, "stepErr");
        chk("stepErr_done_count", done_seen, 1);
        chk("stepErr_err", int'(err_o), 1);
        chk("stepErr_cnt", int'(err_cnt_o), 1);
        chk("stepErr_peak", int'(peak_o), 255);

        // Hold and pre-roll
        step(1'b1, 1'b0, 8'd0, "hold_arm");
        done_seen = 0;
        step(1'b0, 1'b1, 8'd7, "hold_pre");
        step(1'b0, 1'b1, 8'd3, "hold_pre");
        chk("hold_wait_up", int'(up_o), 0);
        step(1'b0, 1'b1, 8'd0, "hold_zero");
        chk("hold_rise_up", int'(up_o), 1);
        step(1'b0, 1'b1, 8'd0, "hold_zero");
        step(1'b0, 1'b1, 8'd1, "hold");
        step(1'b0, 1'b1, 8'd1, "hold");
        ramp_up(2, 255, "hold");
        ramp_down(254, 0, "hold");
        chk("hold_done_count", done_seen, 1);
        chk("hold_cnt", int'(err_cnt_o), 0);

        // Re-arm collision at prev=40
        step(1'b1, 1'b0, 8'd0, "rearm_arm");
        ramp_up(0, 40, "rearm");
        step(1'b1, 1'b1, 8'd41, "rearm_collide");
        chk("rearm_up", int'(up_o), 0);
        chk("rearm_busy", int'(busy_o), 1);
        chk("rearm_peak", int'(peak_o), 0);
        step(1'b0, 1'b1, 8'd42, "rearm_after");

        // Saturation on 2-bit counter instance
        sat_step(1'b1, 1'b0, 8'd0, 0, 0);
        sat_step(1'b0, 1'b1, 8'd0, 0, 0);
        for (int n = 1; n <= 5; n++)
            sat_step(1'b0, 1'b1, (n % 2 == 1) ? 8'd5 : 8'd0, (n < 3) ? n : 3, 1);

        // Async reset mid-FALL
        step(1'b1, 1'b0, 8'd0, "arst_arm");
        done_seen = 0;
        ramp_up(0, 255, "arst");
        ramp_down(254, 100, "arst");
        #3;
        rst_i = 1'b0;
        #1;
        model_reset();
        check("arst_immediate");
        step(1'b0, 1'b1, 8'd99, "arst_held");
        step(1'b0, 1'b1, 8'd98, "arst_held");
        rst_i = 1'b1;
        step(1'b0, 1'b1, 8'd0, "arst_ignored");
        step(1'b0, 1'b1, 8'd1, "arst_ignored");
        chk("arst_done_count", done_seen, 0);
        chk("arst_busy", int'(busy_o), 0);
        step(1'b1, 1'b0, 8'd0, "arst_rearm");

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            int r, k;
            logic [7:0] d;
            r = int'($urandom_range(0, 99));
            k = int'($urandom_range(0, 9));
            case (k)
                0, 1, 2, 3: d = 8'((m_prev + 1) % 256);
                4, 5:       d = 8'((m_prev + 255) % 256);
                6:          d = 8'(m_prev);
                7:          d = 8'd0;
                8:          d = 8'd255;
                default:    d = 8'($urandom_range(0, 255));
            endcase
            if (r < 2)       step(1'b1, ($urandom_range(0, 1) == 1), d, "rand");
            else if (r < 90) step(1'b0, 1'b1, d, "rand");
            else             step(1'b0, 1'b0, d, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
